// File: rtl/operand_forward_ctrl.sv
// EX-stage operand forwarding select, load-use / HI-LO stall detection and
// the mult/div busy counter for the 5-stage pipeline.
module operand_forward_ctrl #(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_md_start,
    input  logic       id_hilo_rd,
    input  logic       ex_wr_en,
    input  logic [4:0] ex_wr_addr,
    input  logic       ex_is_load,
    input  logic       mem_wr_en,
    input  logic [4:0] mem_wr_addr,
    input  logic       wb_wr_en,
    input  logic [4:0] wb_wr_addr,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       bubble,
    output logic       md_busy
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    logic [CNT_W-1:0] md_cnt;
    logic [1:0]       a_sel_nxt;
    logic [1:0]       b_sel_nxt;
    logic             load_use;
    logic             md_stall;

    // Priority select: youngest producer (EX) wins over MEM, then WB.
    function automatic logic [1:0] pick_sel(
        input logic       used,
        input logic [4:0] src,
        input logic       ex_en,
        input logic [4:0] ex_addr,
        input logic       mem_en,
        input logic [4:0] mem_addr,
        input logic       wb_en,
        input logic [4:0] wb_addr
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (used && (src != 5'd0)) begin
            if (ex_en && (ex_addr == src))
                sel = SEL_EX;
            else if (mem_en && (mem_addr == src))
                sel = SEL_MEM;
            else if (wb_en && (wb_addr == src))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        a_sel_nxt = pick_sel(id_rs_used, id_rs, ex_wr_en, ex_wr_addr,
                             mem_wr_en, mem_wr_addr, wb_wr_en, wb_wr_addr);
        b_sel_nxt = pick_sel(id_rt_used, id_rt, ex_wr_en, ex_wr_addr,
                             mem_wr_en, mem_wr_addr, wb_wr_en, wb_wr_addr);
    end

    // Hazard detection; masked while reset is held.
    always_comb begin
        load_use = ex_is_load && ex_wr_en && (ex_wr_addr != 5'd0) &&
                   ((id_rs_used && (id_rs == ex_wr_addr)) ||
                    (id_rt_used && (id_rt == ex_wr_addr)));
        md_stall = md_busy && (id_md_start || id_hilo_rd);
        stall    = rst_n && (load_use || md_stall);
        bubble   = stall;
    end

    assign md_busy = (md_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else if (stall) begin
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            fwd_a_sel <= a_sel_nxt;
            fwd_b_sel <= b_sel_nxt;
        end
    end

    // Busy counter: loads on accepted issue, counts down to zero and holds.
    always_ff @(posedge clk) begin
        if (!rst_n)
            md_cnt <= '0;
        else if (id_md_start && !stall)
            md_cnt <= CNT_W'(MD_CYCLES);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - CNT_W'(1);
    end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed checks of forwarding selects, stalls and the mult/div busy window.
module tb_operand_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt;
    logic       id_rs_used, id_rt_used, id_md_start, id_hilo_rd;
    logic       ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
    logic [4:0] ex_wr_addr, mem_wr_addr, wb_wr_addr;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, bubble, md_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_forward_ctrl #(.MD_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_md_start(id_md_start), .id_hilo_rd(id_hilo_rd),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble(bubble), .md_busy(md_busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_md_start = 1'b0; id_hilo_rd = 1'b0;
        ex_wr_en = 1'b0; ex_wr_addr = 5'd0; ex_is_load = 1'b0;
        mem_wr_en = 1'b0; mem_wr_addr = 5'd0;
        wb_wr_en = 1'b0; wb_wr_addr = 5'd0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step(); step();
        check("rst_a", 8'(fwd_a_sel), 8'h0);
        check("rst_b", 8'(fwd_b_sel), 8'h0);
        check("rst_busy", 8'(md_busy), 8'h0);
        // Load-use pattern held during reset must not stall.
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd4;
        id_rt = 5'd4; id_rt_used = 1'b1;
        #1;
        check("rst_stall", 8'(stall), 8'h0);
        check("rst_bubble", 8'(bubble), 8'h0);
        idle();
        step();
        rst_n = 1'b1;

        // 1: EX forward to A.
        ex_wr_en = 1'b1; ex_wr_addr = 5'd3; id_rs = 5'd3; id_rs_used = 1'b1;
        #1;
        check("t1_stall", 8'(stall), 8'h0);
        step();
        check("t1_a", 8'(fwd_a_sel), 8'h1);
        check("t1_b", 8'(fwd_b_sel), 8'h0);

        // 2: priority and zero register.
        idle();
        ex_wr_en = 1'b1; ex_wr_addr = 5'd5; mem_wr_en = 1'b1; mem_wr_addr = 5'd5;
        id_rs = 5'd5; id_rs_used = 1'b1; id_rt = 5'd5; id_rt_used = 1'b1;
        step();
        check("t2_ex_pri_a", 8'(fwd_a_sel), 8'h1);
        check("t2_ex_pri_b", 8'(fwd_b_sel), 8'h1);
        ex_wr_addr = 5'd6; wb_wr_en = 1'b1; wb_wr_addr = 5'd5;
        step();
        check("t2_mem_pri", 8'(fwd_a_sel), 8'h2);
        mem_wr_en = 1'b0;
        step();
        check("t2_wb", 8'(fwd_a_sel), 8'h3);
        idle();
        ex_wr_en = 1'b1; ex_wr_addr = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
        step();
        check("t2_zero", 8'(fwd_a_sel), 8'h0);
        idle();
        ex_wr_en = 1'b0; ex_wr_addr = 5'd9; id_rs = 5'd9; id_rs_used = 1'b1;
        step();
        check("t2_no_en", 8'(fwd_a_sel), 8'h0);
        ex_wr_en = 1'b1; id_rs_used = 1'b0;
        step();
        check("t2_unused", 8'(fwd_a_sel), 8'h0);

        // 3: load-use, one bubble then MEM forward.
        idle();
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd4;
        id_rt = 5'd4; id_rt_used = 1'b1;
        id_rs = 5'd7; id_rs_used = 1'b1; mem_wr_en = 1'b1; mem_wr_addr = 5'd7;
        #1;
        check("t3_stall", 8'(stall), 8'h1);
        check("t3_bubble", 8'(bubble), 8'h1);
        step();
        check("t3_b_bubble", 8'(fwd_b_sel), 8'h0);
        check("t3_a_bubble", 8'(fwd_a_sel), 8'h0);
        ex_is_load = 1'b0; ex_wr_en = 1'b0; ex_wr_addr = 5'd0;
        mem_wr_addr = 5'd4; id_rs_used = 1'b0;
        #1;
        check("t3_release", 8'(stall), 8'h0);
        step();
        check("t3_b_mem", 8'(fwd_b_sel), 8'h2);
        idle();
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd0;
        id_rt = 5'd0; id_rt_used = 1'b1;
        #1;
        check("t3_r0_nostall", 8'(stall), 8'h0);

        // 4: busy window and HI/LO read stall.
        idle();
        id_md_start = 1'b1;
        #1;
        check("t4_issue_stall", 8'(stall), 8'h0);
        step();
        id_md_start = 1'b0; id_hilo_rd = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("t4_busy_c%0d", i), 8'(md_busy), 8'h1);
            check($sformatf("t4_stall_c%0d", i), 8'(stall), 8'h1);
            step();
        end
        check("t4_busy_c5", 8'(md_busy), 8'h0);
        check("t4_stall_c5", 8'(stall), 8'h0);

        // 5: issue blocked by load-use, loads the next cycle.
        idle();
        id_md_start = 1'b1;
        ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 5'd4;
        id_rt = 5'd4; id_rt_used = 1'b1;
        #1;
        check("t5_stall", 8'(stall), 8'h1);
        step();
        check("t5_noload", 8'(md_busy), 8'h0);
        ex_is_load = 1'b0;
        #1;
        check("t5_clear", 8'(stall), 8'h0);
        step();
        idle();
        check("t5_load", 8'(md_busy), 8'h1);
        step(); step(); step();
        check("t5_last", 8'(md_busy), 8'h1);
        step();
        check("t5_done", 8'(md_busy), 8'h0);

        // 6: reset mid-operation.
        idle();
        id_md_start = 1'b1;
        step();
        id_md_start = 1'b0;
        ex_wr_en = 1'b1; ex_wr_addr = 5'd3; id_rs = 5'd3; id_rs_used = 1'b1;
        step();
        check("t6_pre_busy", 8'(md_busy), 8'h1);
        check("t6_pre_a", 8'(fwd_a_sel), 8'h1);
        rst_n = 1'b0; id_hilo_rd = 1'b1;
        #1;
        check("t6_rst_stall", 8'(stall), 8'h0);
        step();
        check("t6_busy", 8'(md_busy), 8'h0);
        check("t6_a", 8'(fwd_a_sel), 8'h0);
        check("t6_b", 8'(fwd_b_sel), 8'h0);
        rst_n = 1'b1;
        #1;
        check("t6_post_stall", 8'(stall), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
